// File: rtl/incr_arb_pkg.sv
// Shared constants, slot types and the increment function for incr_share_arb.
// Build option: INCR_SAT_EN makes an all-ones operand saturate instead of wrapping.
package incr_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 3;
    localparam int MAX_W     = 32;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0]        data;
        logic [$clog2(NREQ_DEF)-1:0] id;
        logic                        wrap;
    } rsp_t;

    // Returns {wrap, result}; only the low 'width' bits of operand/result are meaningful.
    function automatic logic [MAX_W:0] incr_f(input logic [MAX_W-1:0] operand,
                                              input int unsigned      width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] result;
        logic             wrap;
        mask   = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        wrap   = ((operand & mask) == mask);
        result = (operand + MAX_W'(1)) & mask;
`ifdef INCR_SAT_EN
        if (wrap) result = mask;
`else
        result = result;
`endif
        return {wrap, result};
    endfunction

endpackage

// File: rtl/incr_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, modulo NREQ.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = IDW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/incr_share_arb.sv
// Round-robin share of one increment datapath among NREQ requesters, single registered response slot.
// Build option: INCR_SAT_EN (saturating increment, see incr_arb_pkg).
//
// state      | meaning
// SLOT_EMPTY | no response held, any valid request can be accepted
// SLOT_FULL  | response held until rsp_ready; reload allowed in the draining cycle
module incr_share_arb
    import incr_arb_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_wrap,
    input  logic                  rsp_ready,
    output logic                  busy
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDW-1:0]   id;
        logic             wrap;
    } slot_t;

    slot_state_t      state_q;
    slot_state_t      state_d;
    slot_t            slot_q;
    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] operand;
    logic [MAX_W:0]   incr_full;
    logic             unused_incr_hi;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // rst_n gates the handshake so nothing is accepted while reset is held.
    assign can_accept = (state_q == SLOT_EMPTY) || rsp_ready;
    assign xfer       = pick_any && can_accept && rst_n;
    assign req_ready  = xfer ? grant : '0;

    assign operand        = req_data[pick_idx*WIDTH +: WIDTH];
    assign incr_full      = incr_f(MAX_W'(operand), WIDTH);
    assign unused_incr_hi = ^incr_full[MAX_W-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SLOT_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (xfer) state_d = SLOT_FULL;
            SLOT_FULL:  if (rsp_ready && !xfer) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            rr_ptr <= '0;
        end else if (xfer) begin
            slot_q.data <= incr_full[WIDTH-1:0];
            slot_q.id   <= pick_idx;
            slot_q.wrap <= incr_full[MAX_W];
            rr_ptr      <= (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
        end
    end

    assign rsp_valid = (state_q == SLOT_FULL);
    assign rsp_data  = slot_q.data;
    assign rsp_id    = slot_q.id;
    assign rsp_wrap  = slot_q.wrap;
    assign busy      = rsp_valid || (|req_valid);

endmodule

// File: tb/tb_incr_share_arb.sv
// Directed bench for incr_share_arb: reference model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_incr_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 3;
    localparam int IDW   = 2;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_wrap;
    logic                  rsp_ready;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    int m_valid, m_data, m_id, m_wrap, m_ptr;
    int exp_g[5] = '{1, 2, 4, 8, 1};
    int exp_d[5] = '{1, 2, 3, 4, 1};

    incr_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_wrap  (rsp_wrap),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic int op_of(input int i);
        logic [WIDTH-1:0] f;
        f = req_data[i*WIDTH +: WIDTH];
        return int'(f);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_id = 0; m_wrap = 0; m_ptr = 0;
    endtask

    // Compare every cycle on the falling edge, away from the register updates.
    always @(negedge clk) begin
        int g;
        int exp_rr;
        if (!rst_n) model_reset();
        g      = model_pick(req_valid, m_ptr);
        exp_rr = (rst_n && g >= 0 && (m_valid == 0 || rsp_ready)) ? (1 << g) : 0;
        chk("req_ready", int'(req_ready), exp_rr);
        chk("rsp_valid", int'(rsp_valid), m_valid);
        chk("rsp_data",  int'(rsp_data),  m_data);
        chk("rsp_id",    int'(rsp_id),    m_id);
        chk("rsp_wrap",  int'(rsp_wrap),  m_wrap);
        chk("busy",      int'(busy),      (m_valid != 0 || req_valid != '0) ? 1 : 0);
    end

    always @(posedge clk) begin
        int g;
        int d;
        if (!rst_n) begin
            model_reset();
        end else begin
            g = model_pick(req_valid, m_ptr);
            if (g >= 0 && (m_valid == 0 || rsp_ready)) begin
                d      = op_of(g);
                m_wrap = (d == MAXV) ? 1 : 0;
                m_data = (d + 1) % (MAXV + 1);
`ifdef INCR_SAT_EN
                if (m_wrap != 0) m_data = MAXV;
`endif
                m_id    = g;
                m_ptr   = (g + 1) % NREQ;
                m_valid = 1;
            end else if (rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int d);
        req_data[i*WIDTH +: WIDTH] = WIDTH'(d);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        step(); step();
        at_neg();
        chk("in_reset_req_ready", int'(req_ready), 0);
        chk("in_reset_rsp_valid", int'(rsp_valid), 0);
        step();
        rst_n = 1'b1;
        at_neg();
        chk("post_reset_rsp_valid", int'(rsp_valid), 0);
        chk("post_reset_req_ready", int'(req_ready), 0);
        chk("post_reset_busy",      int'(busy),      0);
        chk("post_reset_rsp_data",  int'(rsp_data),  0);

        // single request from requester 2
        step();
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        set_req(2, 5);
        at_neg();
        chk("single_grant", int'(req_ready), 4);
        step();
        req_valid = '0;
        at_neg();
        chk("single_valid", int'(rsp_valid), 1);
        chk("single_data",  int'(rsp_data),  6);
        chk("single_id",    int'(rsp_id),    2);
        chk("single_wrap",  int'(rsp_wrap),  0);

        // all-ones operand from requester 0, pointer sits at 3
        step();
        req_valid = 4'b0001;
        set_req(0, 7);
        at_neg();
        chk("wrap_grant", int'(req_ready), 1);
        step();
        req_valid = '0;
        at_neg();
`ifdef INCR_SAT_EN
        chk("wrap_data", int'(rsp_data), 7);
`else
        chk("wrap_data", int'(rsp_data), 0);
`endif
        chk("wrap_flag", int'(rsp_wrap), 1);
        chk("wrap_id",   int'(rsp_id),   0);

        // requester 3 moves the pointer back around to 0
        step();
        req_valid = 4'b1000;
        set_req(3, 2);
        at_neg();
        chk("ptr_wrap_grant", int'(req_ready), 8);
        step();
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_req(i, i);
        at_neg();
        chk("ptr_wrap_data", int'(rsp_data), 3);

        // round robin over all four, one per cycle
        for (int k = 0; k < 5; k++) begin
            if (k > 0) at_neg();
            chk("rr_grant", int'(req_ready), exp_g[k]);
            if (k > 0) chk("rr_data", int'(rsp_data), exp_d[k-1]);
            step();
        end
        req_valid = 4'b0010;
        set_req(1, 3);
        rsp_ready = 1'b0;

        // backpressure for three cycles
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk("bp_ready", int'(req_ready), 0);
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_data",  int'(rsp_data),  exp_d[4]);
            chk("bp_id",    int'(rsp_id),    0);
            step();
        end
        rsp_ready = 1'b1;
        at_neg();
        chk("drain_accept_grant", int'(req_ready), 2);
        step();
        req_valid = '0;
        at_neg();
        chk("drain_accept_valid", int'(rsp_valid), 1);
        chk("drain_accept_id",    int'(rsp_id),    1);
        chk("drain_accept_data",  int'(rsp_data),  4);
        step();
        at_neg();
        chk("drain_only_valid", int'(rsp_valid), 0);
        chk("drain_only_hold",  int'(rsp_data),  4);

        // reset while a response is held
        step();
        req_valid = 4'b0100;
        set_req(2, 0);
        at_neg();
        chk("pre_reset_grant", int'(req_ready), 4);
        step();
        req_valid = '0;
        #1;
        chk("pre_reset_full", int'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", int'(rsp_valid), 0);
        chk("async_reset_data",  int'(rsp_data),  0);
        chk("async_reset_ready", int'(req_ready), 0);
        step(); step();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_req(i, i + 2);
        at_neg();
        chk("post_midreset_grant", int'(req_ready), 1);
        step();
        at_neg();
        chk("post_midreset_id",    int'(rsp_id),    0);
        chk("post_midreset_data",  int'(rsp_data),  3);
        chk("post_midreset_grant2", int'(req_ready), 2);
        step();
        req_valid = '0;
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
